count_display_driver: RTL and testbench

//  Consumes the 6-bit Count of the up/down counter and drives a 2-digit multiplexed 7-segment display.

---
 rtl/count_display_driver_if.sv | 23 ++
 rtl/count_display_driver.sv | 206 ++++++++++++++++++++
 tb/tb_count_display_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/count_display_driver_if.sv
// Display-side bundle of the count display driver: the binary count going in,
// the segment/anode drive, the converted BCD digits and the status strobes coming out.
interface count_display_driver_if;
  logic [5:0] Count;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       update;
  logic       busy;

  // Producer of Count, consumer of the display outputs.
  modport master (
    output Count,
    input  seg, an, bcd_tens, bcd_ones, update, busy
  );

  // The driver itself.
  modport slave (
    input  Count,
    output seg, an, bcd_tens, bcd_ones, update, busy
  );
endinterface

// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 6-bit count.
// A sequential double-dabble FSM turns Count into BCD. A free-running refresh
// counter then alternates the ones and tens digits on the display.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                   Clk,
  input  logic                   reset,
  count_display_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  localparam logic [1:0] AN_ONES = ACTIVE_LOW ? 2'b10 : 2'b01;
  localparam logic [1:0] AN_TENS = ACTIVE_LOW ? 2'b01 : 2'b10;
  localparam logic [1:0] AN_NONE = ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Segment pattern {g,f,e,d,c,b,a} for one BCD digit, in the configured polarity.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] raw;
    case (digit)
      4'd0:    raw = 7'h3F;
      4'd1:    raw = 7'h06;
      4'd2:    raw = 7'h5B;
      4'd3:    raw = 7'h4F;
      4'd4:    raw = 7'h66;
      4'd5:    raw = 7'h6D;
      4'd6:    raw = 7'h7D;
      4'd7:    raw = 7'h07;
      4'd8:    raw = 7'h7F;
      4'd9:    raw = 7'h6F;
      default: raw = 7'h00;
    endcase
    return ACTIVE_LOW ? ~raw : raw;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would overflow the decimal digit after doubling.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  state_t        state_q, state_d;
  logic          force_q, force_d;
  logic [5:0]    last_q, last_d;
  logic [13:0]   shift_q, shift_d;
  logic [2:0]    iter_q, iter_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          update_q, update_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] ref_q, ref_d;
  logic          sel_q, sel_d;     // 0: ones digit lit, 1: tens digit lit
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic [13:0]   shift_adj_s;
  logic [13:0]   shift_next_s;
  logic          trigger_s;

  // Shift register layout is {tens(4), ones(4), bin(6)}; correct both nibbles, then shift left.
  assign shift_adj_s  = {add3(shift_q[13:10]), add3(shift_q[9:6]), shift_q[5:0]};
  assign shift_next_s = {shift_adj_s[12:0], 1'b0};
  assign trigger_s    = force_q || (bus.Count != last_q);

  // FSM state register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: IDLE -> LOAD -> 6x SHIFT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trigger_s) state_d = S_LOAD;
        else           state_d = S_IDLE;
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (iter_q == 3'd5) state_d = S_DONE;
        else                state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: conversion datapath and the BCD/update/busy next values.
  always_comb begin
    force_d  = force_q;
    last_d   = last_q;
    shift_d  = shift_q;
    iter_d   = iter_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    update_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_s) force_d = 1'b0;
        else           force_d = force_q;
      end
      S_LOAD: begin
        shift_d = {8'h00, bus.Count};
        last_d  = bus.Count;
        iter_d  = 3'd0;
      end
      S_SHIFT: begin
        shift_d = shift_next_s;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd5) begin
          // Sixth shift: publish the result so it is visible during DONE.
          tens_d   = shift_next_s[13:10];
          ones_d   = shift_next_s[9:6];
          update_d = 1'b1;
        end else begin
          update_d = 1'b0;
        end
      end
      S_DONE:  update_d = 1'b0;
      default: update_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Conversion and status registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      force_q  <= 1'b1;
      last_q   <= 6'd0;
      shift_q  <= 14'd0;
      iter_q   <= 3'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      force_q  <= force_d;
      last_q   <= last_d;
      shift_q  <= shift_d;
      iter_q   <= iter_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      update_q <= update_d;
      busy_q   <= busy_d;
    end
  end

  // Refresh timing and segment/anode selection from the currently held digits.
  always_comb begin
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      sel_d = ~sel_q;
    end else begin
      ref_d = ref_q + RW'(1);
      sel_d = sel_q;
    end
    if (!sel_q) begin
      an_d  = AN_ONES;
      seg_d = seg_encode(ones_q);
    end else if (BLANK_LEADING && (tens_q == 4'd0)) begin
      an_d  = AN_NONE;
      seg_d = SEG_OFF;
    end else begin
      an_d  = AN_TENS;
      seg_d = seg_encode(tens_q);
    end
  end

  // Display multiplexing registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ref_q <= '0;
      sel_q <= 1'b0;
      an_q  <= AN_ONES;
      seg_q <= seg_encode(4'd0);
    end else begin
      ref_q <= ref_d;
      sel_q <= sel_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
  assign bus.update   = update_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: two instances (active-low with
// blanking, active-high without), a behavioural model, vector table and random stimulus.
module tb_count_display_driver;

  localparam int DIV_A = 4;
  localparam int DIV_B = 3;

  logic Clk;
  logic reset;

  int checks;
  int failures;

  count_display_driver_if ifa ();
  count_display_driver_if ifb ();

  count_display_driver #(.REFRESH_DIV(DIV_A), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
    .Clk(Clk), .reset(reset), .bus(ifa.slave)
  );
  count_display_driver #(.REFRESH_DIV(DIV_B), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_b (
    .Clk(Clk), .reset(reset), .bus(ifb.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Active-high segment patterns for digits 0..9.
  logic [6:0] enc_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Behavioural model state (values after the most recent clock edge).
  int         m_phase;   // 0 idle, 1 load, 2..7 shifting, 8 done
  bit         m_force;
  int         m_last;
  int         m_cap;
  int         m_tens;
  int         m_ones;
  bit         m_upd;
  int         ref_a, sel_a, ref_b, sel_b;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;

  typedef struct {
    logic [5:0] cnt;
    int         exp_tens;
    int         exp_ones;
  } vec_t;
  vec_t vecs [7];

  function automatic void disp_exp(input bit al, input bit bl, input int sel, input int tens,
                                   input int ones, output logic [6:0] s, output logic [1:0] a);
    logic [6:0] raw;
    logic [1:0] an_hi;
    if (sel == 0) begin
      raw = enc_tab[ones]; an_hi = 2'b01;
    end else if (bl && tens == 0) begin
      raw = 7'h00; an_hi = 2'b00;
    end else begin
      raw = enc_tab[tens]; an_hi = 2'b10;
    end
    s = al ? ~raw : raw;
    a = al ? ~an_hi : an_hi;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_force = 1'b1; m_last = 0; m_cap = 0;
    m_tens = 0; m_ones = 0; m_upd = 1'b0;
    ref_a = 0; sel_a = 0; ref_b = 0; sel_b = 0;
    disp_exp(1'b1, 1'b1, 0, 0, 0, seg_a, an_a);
    disp_exp(1'b0, 1'b0, 0, 0, 0, seg_b, an_b);
  endtask

  // Advance the model by one clock edge with Count = c at that edge.
  task automatic model_step(input int c);
    disp_exp(1'b1, 1'b1, sel_a, m_tens, m_ones, seg_a, an_a);
    disp_exp(1'b0, 1'b0, sel_b, m_tens, m_ones, seg_b, an_b);
    if (ref_a == DIV_A - 1) begin ref_a = 0; sel_a = 1 - sel_a; end else ref_a = ref_a + 1;
    if (ref_b == DIV_B - 1) begin ref_b = 0; sel_b = 1 - sel_b; end else ref_b = ref_b + 1;
    m_upd = 1'b0;
    case (m_phase)
      0: if (m_force || c != m_last) begin m_force = 1'b0; m_phase = 1; end
      1: begin m_cap = c; m_last = c; m_phase = 2; end
      7: begin m_tens = m_cap / 10; m_ones = m_cap % 10; m_upd = 1'b1; m_phase = 8; end
      8: m_phase = 0;
      default: m_phase = m_phase + 1;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_seg",  32'(ifa.seg),      32'(seg_a));
    chk("a_an",   32'(ifa.an),       32'(an_a));
    chk("a_tens", 32'(ifa.bcd_tens), 32'(m_tens));
    chk("a_ones", 32'(ifa.bcd_ones), 32'(m_ones));
    chk("a_upd",  32'(ifa.update),   32'(m_upd));
    chk("a_busy", 32'(ifa.busy),     32'(m_phase != 0));
    chk("b_seg",  32'(ifb.seg),      32'(seg_b));
    chk("b_an",   32'(ifb.an),       32'(an_b));
    chk("b_tens", 32'(ifb.bcd_tens), 32'(m_tens));
    chk("b_ones", 32'(ifb.bcd_ones), 32'(m_ones));
    chk("b_upd",  32'(ifb.update),   32'(m_upd));
    chk("b_busy", 32'(ifb.busy),     32'(m_phase != 0));
  endtask

  // One clock cycle with Count = c, then check every output against the model.
  task automatic cycle(input int c);
    ifa.Count = 6'(c);
    ifb.Count = 6'(c);
    model_step(c);
    @(posedge Clk);
    @(negedge Clk);
    check_all();
  endtask

  // Reset asserted at a negedge: outputs must be at reset values immediately.
  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge Clk);
    @(negedge Clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int n_upd;
    int found;
    int blank_cnt;
    int v;
    int mode;
    int len;
    int res_q[$];

    checks = 0;
    failures = 0;
    vecs[0] = '{6'd37, 3, 7};
    vecs[1] = '{6'd63, 6, 3};
    vecs[2] = '{6'd0,  0, 0};
    vecs[3] = '{6'd9,  0, 9};
    vecs[4] = '{6'd10, 1, 0};
    vecs[5] = '{6'd59, 5, 9};
    vecs[6] = '{6'd20, 2, 0};

    // Reset state.
    reset = 1'b0;
    ifa.Count = 6'd0;
    ifb.Count = 6'd0;
    #2 reset = 1'b1;
    model_reset();
    @(negedge Clk);
    check_all();
    chk("rst_seg", 32'(ifa.seg), 32'(7'b1000000));
    chk("rst_an",  32'(ifa.an),  32'(2'b10));
    @(negedge Clk);
    reset = 1'b0;

    // Forced first conversion of Count=0 lands 8 cycles after release.
    for (int i = 0; i < 8; i++) cycle(0);
    chk("first_upd", 32'(ifa.update), 32'd1);
    chk("first_tens", 32'(ifa.bcd_tens), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0);

    // Vector table: each held value converts to the expected digits with exactly one update.
    for (int k = 0; k < 7; k++) begin
      n_upd = 0;
      for (int i = 0; i < 12; i++) begin
        cycle(int'(vecs[k].cnt));
        if (ifa.update === 1'b1) n_upd++;
      end
      chk("vec_tens", 32'(ifa.bcd_tens), 32'(vecs[k].exp_tens));
      chk("vec_ones", 32'(ifa.bcd_ones), 32'(vecs[k].exp_ones));
      chk("vec_nupd", 32'(n_upd), 32'd1);
    end

    // Count 37: ones slot shows '7' in active-low form.
    for (int i = 0; i < 12; i++) cycle(37);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (found == 0) begin
        cycle(37);
        if (ifa.an === 2'b10) begin
          chk("seg37_ones", 32'(ifa.seg), 32'(7'b1111000));
          found = 1;
        end
      end
    end
    chk("seg37_seen", 32'(found), 32'd1);

    // Count 5 with blanking: ones lit half the time, blank the other half.
    for (int i = 0; i < 12; i++) cycle(5);
    blank_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(5);
      if (ifa.an === 2'b11) blank_cnt++;
      else chk("seg5_ones", 32'(ifa.seg), 32'(7'b0010010));
    end
    chk("blank_cnt", 32'(blank_cnt), 32'd8);

    // 10 -> 11 while shifting: result 10, then exactly one more conversion giving 11.
    res_q = {};
    cycle(10);
    if (ifa.update === 1'b1) res_q.push_back(ifa.bcd_tens * 10 + ifa.bcd_ones);
    cycle(10);
    if (ifa.update === 1'b1) res_q.push_back(ifa.bcd_tens * 10 + ifa.bcd_ones);
    for (int i = 0; i < 24; i++) begin
      cycle(11);
      if (ifa.update === 1'b1) res_q.push_back(ifa.bcd_tens * 10 + ifa.bcd_ones);
    end
    chk("stale_nupd", 32'(res_q.size()), 32'd2);
    if (res_q.size() >= 2) begin
      chk("stale_first",  32'(res_q[0]), 32'd10);
      chk("stale_second", 32'(res_q[1]), 32'd11);
    end

    // Reset mid-SHIFT with Count=42, then a fresh conversion after release.
    for (int i = 0; i < 4; i++) cycle(42);
    chk("mid_busy", 32'(ifa.busy), 32'd1);
    reset_pulse();
    chk("abort_tens", 32'(ifa.bcd_tens), 32'd0);
    for (int i = 0; i < 12; i++) cycle(42);
    chk("post_tens", 32'(ifa.bcd_tens), 32'd4);
    chk("post_ones", 32'(ifa.bcd_ones), 32'd2);

    // Random holds and ramps with occasional resets, all against the model.
    v = 42;
    for (int blk = 0; blk < 60; blk++) begin
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 15));
      if (mode == 0) v = int'($urandom_range(0, 63));
      for (int i = 0; i < len; i++) begin
        if (mode == 1) v = (v + 1) % 64;
        else if (mode == 2) v = (v + 63) % 64;
        cycle(v);
      end
      if ($urandom_range(0, 19) == 0) reset_pulse();
    end
    for (int i = 0; i < 20; i++) cycle(v);
    chk("final_tens", 32'(ifa.bcd_tens), 32'(v / 10));
    chk("final_ones", 32'(ifa.bcd_ones), 32'(v % 10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
